// File: rtl/ptosda_arbiter.sv
// Round-robin arbiter that shares one SDA/SCL serializer among NREQ nibble producers.
// Optional WAIT_DONE watchdog enabled by defining ARB_TIMEOUT_EN.
module ptosda_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 4,
    parameter int TMO  = 255,
    localparam int OW  = $clog2(NREQ)
) (
    input  logic               sclk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic [DW-1:0]      tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    input  logic               tx_done,
    output logic               busy,
    output logic [OW-1:0]      owner,
    output logic               tmo_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [NREQ-1:0]    r_gnt;
    logic [DW-1:0]      r_tx_data;
    logic               r_tx_valid;
    logic               r_busy;
    logic [OW-1:0]      r_owner;
    logic [OW-1:0]      r_last_owner;
    logic               r_tmo_err;
    logic [OW-1:0]      w_win;
    logic [NREQ-1:0]    w_win_onehot;

    // First set request bit scanning upward from (last+1), wrapping; the
    // downward loop leaves the nearest candidate as the final assignment.
    function automatic logic [OW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [OW-1:0]   last);
        logic [OW-1:0] idx;
        logic [OW-1:0] win;
        win = {OW{1'b0}};
        for (int k = NREQ; k >= 1; k--) begin
            idx = last + OW'(k);
            if (r[idx]) begin
                win = idx;
            end
        end
        return win;
    endfunction

    // Combinational winner selection for the next grant.
    always_comb begin
        w_win        = rr_pick(req, r_last_owner);
        w_win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = (TMO < 2) ? 1 : $clog2(TMO + 1);
    logic [CW-1:0] r_cnt;
`endif

    // Arbitration / handshake sequencer with registered outputs.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_gnt        <= {NREQ{1'b0}};
            r_tx_data    <= {DW{1'b0}};
            r_tx_valid   <= 1'b0;
            r_busy       <= 1'b0;
            r_owner      <= {OW{1'b0}};
            r_last_owner <= OW'(NREQ - 1);
            r_tmo_err    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_cnt        <= {CW{1'b0}};
`endif
        end else begin
            r_gnt     <= {NREQ{1'b0}};
            r_tmo_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_gnt      <= w_win_onehot;
                        r_tx_data  <= req_data[w_win*DW +: DW];
                        r_owner    <= w_win;
                        r_tx_valid <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= SEND;
                    end
                end
                SEND: begin
                    // tx_done is deliberately ignored here, even on the accept edge.
                    if (r_tx_valid && tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= WAIT_DONE;
`ifdef ARB_TIMEOUT_EN
                        r_cnt      <= {CW{1'b0}};
`endif
                    end
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        r_last_owner <= r_owner;
                        r_busy       <= 1'b0;
                        r_state      <= IDLE;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (r_cnt == CW'(TMO - 1)) begin
                        r_tmo_err    <= 1'b1;
                        r_last_owner <= r_owner;
                        r_busy       <= 1'b0;
                        r_state      <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                    end
`endif
                end
                default: begin
                    r_state    <= IDLE;
                    r_tx_valid <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign gnt      = r_gnt;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign busy     = r_busy;
    assign owner    = r_owner;
    assign tmo_err  = r_tmo_err;

endmodule

// File: tb/tb_ptosda_arbiter.sv
// Directed self-checking bench for ptosda_arbiter (NREQ=4, DW=4, TMO=16).
// Covers both builds, with and without ARB_TIMEOUT_EN.
module tb_ptosda_arbiter;

    logic        sclk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] req_data;
    logic [3:0]  gnt;
    logic [3:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_done;
    logic        busy;
    logic [1:0]  owner;
    logic        tmo_err;

    int checks = 0;
    int errors = 0;

    ptosda_arbiter #(.NREQ(4), .DW(4), .TMO(16)) dut (
        .sclk     (sclk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_done  (tx_done),
        .busy     (busy),
        .owner    (owner),
        .tmo_err  (tmo_err)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sclk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin : stim
        logic [1:0] order [5];
        order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;

        rst      = 1'b0;
        req      = 4'hF;
        req_data = {4'h4, 4'h3, 4'h2, 4'h1};
        tx_ready = 1'b1;
        tx_done  = 1'b0;
        tick(3);
        chk("rst_gnt",     32'(gnt),      32'h0);
        chk("rst_txdata",  32'(tx_data),  32'h0);
        chk("rst_txvalid", 32'(tx_valid), 32'h0);
        chk("rst_busy",    32'(busy),     32'h0);
        chk("rst_owner",   32'(owner),    32'h0);
        chk("rst_tmo",     32'(tmo_err),  32'h0);
        rst = 1'b1;

        // req=F held: round-robin 0,1,2,3,0 with an IDLE gap after each tx_done
        for (int t = 0; t < 5; t++) begin
            tick(1);
            chk("rr_gnt",    32'(gnt),      32'(4'b0001 << order[t]));
            chk("rr_data",   32'(tx_data),  32'(order[t]) + 32'd1);
            chk("rr_owner",  32'(owner),    32'(order[t]));
            chk("rr_valid",  32'(tx_valid), 32'h1);
            tick(1);
            chk("rr_accept", 32'(tx_valid), 32'h0);
            chk("rr_gnt1cy", 32'(gnt),      32'h0);
            tick(5);
            chk("rr_busy_w", 32'(busy),     32'h1);
            tx_done = 1'b1;
            tick(1);
            tx_done = 1'b0;
            chk("rr_idle",   32'(busy),     32'h0);
            chk("rr_gap",    32'(gnt),      32'h0);
            if (t == 4) begin
                req      = 4'b0100;
                req_data = {4'h4, 4'hA, 4'h2, 4'h1};
            end
        end

        // Single requester 2 with data A
        tick(1);
        chk("one_gnt",   32'(gnt),     32'h4);
        chk("one_data",  32'(tx_data), 32'hA);
        chk("one_owner", 32'(owner),   32'h2);
        req = 4'b0000;
        tick(1);
        chk("one_gnt_pulse", 32'(gnt),      32'h0);
        chk("one_accept",    32'(tx_valid), 32'h0);
        tick(4);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        chk("one_done_busy",  32'(busy),  32'h0);
        chk("one_owner_keep", 32'(owner), 32'h2);
        tick(2);
        chk("one_no_regrant", 32'(gnt),   32'h0);

        // Stall: requester 3 wins after owner 2; tx_done in SEND ignored
        req      = 4'b1001;
        req_data = {4'h7, 4'hA, 4'h2, 4'h1};
        tick(1);
        chk("stall_gnt",   32'(gnt),   32'h8);
        chk("stall_owner", 32'(owner), 32'h3);
        req      = 4'b0000;
        tx_ready = 1'b0;
        tx_done  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            chk("stall_valid", 32'(tx_valid), 32'h1);
            chk("stall_data",  32'(tx_data),  32'h7);
            chk("stall_busy",  32'(busy),     32'h1);
        end
        tx_ready = 1'b1;
        tick(1);
        chk("stall_accept",    32'(tx_valid), 32'h0);
        chk("done_on_accept",  32'(busy),     32'h1);
        tx_done = 1'b0;
        tick(1);
        chk("wait_still_busy", 32'(busy),     32'h1);

        // Reset mid-WAIT_DONE (owner 3): pointer returns to NREQ-1
        rst = 1'b0;
        #1;
        chk("arst_busy",  32'(busy),     32'h0);
        chk("arst_valid", 32'(tx_valid), 32'h0);
        chk("arst_owner", 32'(owner),    32'h0);
        req = 4'b1010;
        tick(2);
        chk("arst_nogrant", 32'(gnt), 32'h0);
        rst = 1'b1;
        tick(1);
        chk("post_rst_gnt",   32'(gnt),   32'h2);
        chk("post_rst_owner", 32'(owner), 32'h1);
        tick(1);
        chk("post_rst_accept", 32'(tx_valid), 32'h0);

`ifdef ARB_TIMEOUT_EN
        for (int c = 0; c < 15; c++) begin
            tick(1);
            chk("tmo_quiet", 32'(tmo_err), 32'h0);
            chk("tmo_busy",  32'(busy),    32'h1);
        end
        tick(1);
        chk("tmo_pulse",     32'(tmo_err), 32'h1);
        chk("tmo_busy_drop", 32'(busy),    32'h0);
        tick(1);
        chk("tmo_pulse_end", 32'(tmo_err), 32'h0);
        chk("tmo_next_gnt",  32'(gnt),     32'h8);
        chk("tmo_next_own",  32'(owner),   32'h3);
`else
        for (int c = 0; c < 100; c++) begin
            tick(1);
            chk("notmo_busy", 32'(busy),    32'h1);
            chk("notmo_err",  32'(tmo_err), 32'h0);
            chk("notmo_gnt",  32'(gnt),     32'h0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
